ldl_hot2bin_pipe: RTL and testbench

Pipelined one-hot to binary encoder with a valid/ready handshake and illegal-code detection. It performs the inverse of the library's bin2hot decoder. It converts a `(1<<WIDTH)`-bit one-hot vector into a `WIDTH`-bit index. It flags zero-hot and multi-hot inputs and keeps a saturating error count. It sits on streaming datapaths that carry one-hot selects, such as arbiter grants or FSM state vectors, and must recover a binary index at full clock rate.

---
 rtl/ldl_hot2bin_pipe_pkg.sv | 9 +
 rtl/ldl_hot2bin_pipe_if.sv | 25 ++
 rtl/ldl_hot2bin_pipe_enc.sv | 18 +
 rtl/ldl_hot2bin_pipe.sv | 41 ++++
 tb/tb_ldl_hot2bin_pipe.sv | 138 +++++++++++++
 5 files changed

// File: rtl/ldl_hot2bin_pipe_pkg.sv
// ldl_hot2bin_pipe_pkg: shared constants and constant functions for the hot2bin pipe
package ldl_hot2bin_pipe_pkg;
  localparam int CNT_W_DEF = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ldl_hot2bin_pipe_if.sv
// ldl_hot2bin_pipe_if: input/output stream handshake and error-counter signals
interface ldl_hot2bin_pipe_if
  import ldl_hot2bin_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = CNT_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [(1<<WIDTH)-1:0] x;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      y;
  logic                  err;
  logic                  cnt_clr;
  logic [CNT_W-1:0]      err_cnt;
  modport master (
    output in_valid, x, out_ready, cnt_clr,
    input  in_ready, out_valid, y, err, err_cnt
  );
  modport slave (
    input  in_valid, x, out_ready, cnt_clr,
    output in_ready, out_valid, y, err, err_cnt
  );
endinterface

// File: rtl/ldl_hot2bin_pipe_enc.sv
// ldl_hot2bin_pipe_enc: combinational one-hot to binary encoder with zero/multi-hot flag
module ldl_hot2bin_pipe_enc
  import ldl_hot2bin_pipe_pkg::*;
#(
  parameter int N = 16,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         err
);
  // OR together the indices of every set bit; exact for legal one-hot input
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) y = x[i] ? (y | W'(i)) : y;
    err = (x == '0) | ((x & (x - N'(1))) != '0);
  end
endmodule

// File: rtl/ldl_hot2bin_pipe.sv
// ldl_hot2bin_pipe: two-stage one-hot to binary encoder with handshake and error count
module ldl_hot2bin_pipe
  import ldl_hot2bin_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  ldl_hot2bin_pipe_if.slave bus
);
  logic                  v1, v2, adv1, adv2, err_n;
  logic [(1<<WIDTH)-1:0] x_q;
  logic [WIDTH-1:0]      y_n;
  ldl_hot2bin_pipe_enc #(.N(1 << WIDTH)) enc (.x(x_q), .y(y_n), .err(err_n));
  assign adv2          = !v2 | bus.out_ready;
  assign adv1          = !v1 | adv2;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2;
  // S1 captures x, S2 captures the encoding; an advancing stage without data goes empty
  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      x_q         <= '0;
      bus.y       <= '0;
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (adv1 && bus.in_valid) x_q <= bus.x;
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        bus.y   <= y_n;
        bus.err <= err_n;
      end
      if (bus.cnt_clr) bus.err_cnt <= '0;
      else if (adv2 && v1 && err_n && bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ldl_hot2bin_pipe.sv
// tb_ldl_hot2bin_pipe: directed self-checking bench for the hot2bin pipe
module tb_ldl_hot2bin_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   miss = 0;
  ldl_hot2bin_pipe_if #(.WIDTH(4), .CNT_W(8)) bus ();
  ldl_hot2bin_pipe #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.in_valid = 1'b1; bus.x = 16'h0001; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    step; step;
    vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vecs++; if (bus.y !== 4'd0) begin miss++; $display("FAIL reset_y got %0d want 0", bus.y); end
    vecs++; if (bus.err !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", bus.err); end
    vecs++; if (bus.err_cnt !== 8'd0) begin miss++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
    vecs++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    rst = 1'b0; bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step;
      vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset_idle%0d out_valid got %b want 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_stream;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      bus.in_valid = (c < 16);
      bus.x = 16'(1 << (c & 15));
      #1;
      if (c < 16) begin
        vecs++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, bus.in_ready); end
      end
      step;
      if (c >= 1 && c <= 16) begin
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.y !== 4'(c - 1) || bus.err !== 1'b0) begin
          miss++; $display("FAIL stream_out c=%0d got v=%b y=%0d e=%b want v=1 y=%0d e=0", c, bus.out_valid, bus.y, bus.err, c - 1);
        end
      end else begin
        vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL stream_idle c=%0d out_valid got %b want 0", c, bus.out_valid); end
      end
    end
  endtask

  task automatic test_illegal;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.x = 16'h0000; step;
    bus.x = 16'h0006; step;
    vecs++; if (bus.out_valid !== 1'b1 || bus.y !== 4'd0 || bus.err !== 1'b1) begin miss++; $display("FAIL zero_hot got v=%b y=%0d e=%b want v=1 y=0 e=1", bus.out_valid, bus.y, bus.err); end
    vecs++; if (bus.err_cnt !== 8'd1) begin miss++; $display("FAIL zero_hot_cnt got %0d want 1", bus.err_cnt); end
    bus.in_valid = 1'b0; step;
    vecs++; if (bus.out_valid !== 1'b1 || bus.y !== 4'd3 || bus.err !== 1'b1) begin miss++; $display("FAIL multi_hot got v=%b y=%0d e=%b want v=1 y=3 e=1", bus.out_valid, bus.y, bus.err); end
    vecs++; if (bus.err_cnt !== 8'd2) begin miss++; $display("FAIL multi_hot_cnt got %0d want 2", bus.err_cnt); end
    step;
    vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL illegal_drain out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int got = 0;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = (c >= 5);
      bus.in_valid = (k < 4);
      bus.x = 16'(1 << (k & 3));
      #1;
      if (c >= 2 && c < 5) begin
        vecs++; if (bus.in_ready !== 1'b0) begin miss++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, bus.in_ready); end
        vecs++; if (bus.out_valid !== 1'b1 || bus.y !== 4'd0) begin miss++; $display("FAIL bp_hold c=%0d got v=%b y=%0d want v=1 y=0", c, bus.out_valid, bus.y); end
      end
      if (c == 5) begin
        vecs++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL bp_release in_ready got %b want 1", bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        vecs++;
        if (bus.y !== got[3:0] || bus.err !== 1'b0) begin miss++; $display("FAIL bp_order got y=%0d e=%b want y=%0d e=0", bus.y, bus.err, got); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      step;
    end
    vecs++; if (got !== 4) begin miss++; $display("FAIL bp_count got %0d want 4", got); end
  endtask

  task automatic test_counter;
    bus.out_ready = 1'b1; bus.in_valid = 1'b0; bus.cnt_clr = 1'b1; step;
    vecs++; if (bus.err_cnt !== 8'd0) begin miss++; $display("FAIL cnt_clear got %0d want 0", bus.err_cnt); end
    bus.cnt_clr = 1'b0; bus.in_valid = 1'b1; bus.x = 16'h0000;
    for (int c = 0; c < 300; c++) step;
    bus.in_valid = 1'b0; step; step;
    vecs++; if (bus.err_cnt !== 8'd255) begin miss++; $display("FAIL cnt_saturate got %0d want 255", bus.err_cnt); end
    bus.in_valid = 1'b1; step;
    bus.in_valid = 1'b0; bus.cnt_clr = 1'b1; step;
    vecs++; if (bus.err_cnt !== 8'd0 || bus.out_valid !== 1'b1 || bus.err !== 1'b1) begin miss++; $display("FAIL cnt_clr_prio got cnt=%0d v=%b e=%b want cnt=0 v=1 e=1", bus.err_cnt, bus.out_valid, bus.err); end
    bus.cnt_clr = 1'b0; step;
    vecs++; if (bus.err_cnt !== 8'd0) begin miss++; $display("FAIL cnt_after_clr got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.x = 16'h0000; step;
    bus.x = 16'h0040; step;
    bus.in_valid = 1'b0; #1;
    vecs++; if (bus.out_valid !== 1'b1 || bus.err_cnt !== 8'd1 || bus.in_ready !== 1'b0) begin miss++; $display("FAIL mid_full got v=%b cnt=%0d rdy=%b want v=1 cnt=1 rdy=0", bus.out_valid, bus.err_cnt, bus.in_ready); end
    rst = 1'b1; step;
    rst = 1'b0;
    vecs++; if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin miss++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", bus.out_valid, bus.err_cnt, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step;
      vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL mid_ghost%0d out_valid got %b want 0", c, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.x = 16'h0200; step;
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL mid_early out_valid got %b want 0", bus.out_valid); end
    step;
    vecs++; if (bus.out_valid !== 1'b1 || bus.y !== 4'd9 || bus.err !== 1'b0) begin miss++; $display("FAIL mid_next got v=%b y=%0d e=%b want v=1 y=9 e=0", bus.out_valid, bus.y, bus.err); end
    step;
    vecs++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL mid_drain out_valid got %b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    test_reset;
    test_stream;
    test_illegal;
    test_backpressure;
    test_counter;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
